// File: rtl/dot_result_unpack.sv
// Receive-side unpacker for the packed dot-product result word: validates the flag bits,
// extracts the 32-bit sum and buffers good sums in a small FIFO popped over valid/ready.
module dot_result_unpack #(
  parameter int DEPTH = 4,
  parameter int ERR_W = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [52:0]      in_word,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_sum,
  input  logic             err_clr,
  output logic [ERR_W-1:0] err_cnt,
  output logic             err_sticky,
  output logic [CNT_W-1:0] word_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;

  logic        flags_ok;
  logic [31:0] sum;
  logic        accept;
  logic        push;
  logic        bad;
  logic        pop;

  assign flags_ok  = (&in_word[52:33]) & in_word[0];
  assign sum       = in_word[32:1];
  assign in_ready  = (count != FULL);
  assign out_valid = (count != '0);
  assign accept    = in_valid & in_ready;
  assign push      = accept & flags_ok;
  assign bad       = accept & ~flags_ok;
  assign pop       = out_valid & out_ready;
  assign out_sum   = out_valid ? mem[rd_ptr] : 32'h0;

  // Storage is not reset; validity is tracked entirely by count and the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= sum;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      word_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr   <= wr_ptr + 1'b1;
        word_cnt <= word_cnt + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // A clear in the same cycle as a bad word takes priority, so that word goes uncounted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt    <= '0;
      err_sticky <= 1'b0;
    end else if (err_clr) begin
      err_cnt    <= '0;
      err_sticky <= 1'b0;
    end else if (bad) begin
      err_sticky <= 1'b1;
      if (err_cnt != '1) begin
        err_cnt <= err_cnt + 1'b1;
      end
    end
  end

endmodule
